// File: rtl/branch_predict_table_pkg.sv
// branch_predict_table_pkg: counter states, entry sizing and PC slicing helpers shared by the predictor.
package branch_predict_table_pkg;
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;
  localparam int unsigned PC_INC = 4;
  // An entry is {valid, tag, target, ctr}.
  function automatic int entry_bits(input int pc_bits, input int index_bits);
    return 1 + (pc_bits - index_bits - 2) + pc_bits + 2;
  endfunction
  function automatic logic [63:0] pc_index(input logic [63:0] pc, input int index_bits);
    return (pc >> 2) & ((64'd1 << index_bits) - 64'd1);
  endfunction
  function automatic logic [63:0] pc_tag(input logic [63:0] pc, input int index_bits);
    return pc >> (index_bits + 2);
  endfunction
endpackage

// File: rtl/branch_predict_table_bpt_counter2.sv
// bpt_counter2: next state of a 2-bit saturating taken/not-taken counter.
module bpt_counter2
  import branch_predict_table_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);
  // Step toward ST on taken, toward SNT on not taken, holding at the ends.
  always_comb begin
    ctr_next = taken ? ((ctr == ST) ? ST : ctr + 2'd1) : ((ctr == SNT) ? SNT : ctr - 2'd1);
  end
endmodule

// File: rtl/branch_predict_table.sv
// branch_predict_table: direct-mapped 2-bit-counter branch predictor with EX-stage update and mispredict flagging.
// Optional macro BPT_BYPASS_EN: same-index lookup sees the entry being written this cycle.
module branch_predict_table
  import branch_predict_table_pkg::*;
#(
  parameter int PcBits      = 32,
  parameter int IndexBits   = 6,
  parameter int InitCounter = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              ClockEnable,
  input  logic              Tick,
  input  logic              Invalidate,
  input  logic [PcBits-1:0] IF_PC,
  output logic              PredictJump,
  output logic [PcBits-1:0] PredictTarget,
  input  logic              EX_Valid,
  input  logic              EX_IsBranch,
  input  logic [PcBits-1:0] EX_PC,
  input  logic              EX_PredictJump,
  input  logic [PcBits-1:0] EX_PredictTarget,
  input  logic              EX_Taken,
  input  logic [PcBits-1:0] EX_Target,
  output logic              Mispredict,
  output logic [PcBits-1:0] RedirectPC
);
  localparam int TagBits   = PcBits - IndexBits - 2;
  localparam int EntryBits = entry_bits(PcBits, IndexBits);
  localparam int Entries   = 1 << IndexBits;
  logic [EntryBits-1:0] mem [Entries];
  logic [IndexBits-1:0] if_idx, ex_idx;
  logic [TagBits-1:0]   if_tag, ex_tag;
  logic [EntryBits-1:0] if_ent, ex_ent, new_ent;
  logic [1:0]           ctr_next;
  logic                 adv, upd, wr, ex_hit, if_hit;
  assign adv    = ClockEnable & Tick;
  assign upd    = EX_Valid & EX_IsBranch & adv;
  assign if_idx = IndexBits'(pc_index(64'(IF_PC), IndexBits));
  assign ex_idx = IndexBits'(pc_index(64'(EX_PC), IndexBits));
  assign if_tag = TagBits'(pc_tag(64'(IF_PC), IndexBits));
  assign ex_tag = TagBits'(pc_tag(64'(EX_PC), IndexBits));
  assign ex_ent = mem[ex_idx];
  assign ex_hit = ex_ent[EntryBits-1] && (ex_ent[EntryBits-2 -: TagBits] == ex_tag);
  // A not-taken miss leaves the table alone; invalidate drops any same-cycle write.
  assign wr     = upd & ~Invalidate & (ex_hit | EX_Taken);
  bpt_counter2 u_ctr (.ctr(ex_ent[1:0]), .taken(EX_Taken), .ctr_next(ctr_next));
  // Hit: train counter and refresh target on taken; miss: allocate as weakly taken.
  always_comb begin
    new_ent = ex_hit ? {1'b1, ex_tag, EX_Taken ? EX_Target : ex_ent[PcBits+1:2], ctr_next}
                     : {1'b1, ex_tag, EX_Target, WT};
  end
`ifdef BPT_BYPASS_EN
  assign if_ent = (wr && (if_idx == ex_idx)) ? new_ent : mem[if_idx];
`else
  assign if_ent = mem[if_idx];
`endif
  assign if_hit        = if_ent[EntryBits-1] && (if_ent[EntryBits-2 -: TagBits] == if_tag);
  assign PredictJump   = if_hit & if_ent[1];
  assign PredictTarget = PredictJump ? if_ent[PcBits+1:2] : IF_PC + PcBits'(PC_INC);
  assign Mispredict    = EX_Valid & EX_IsBranch &
                         ((EX_PredictJump != EX_Taken) | (EX_Taken & (EX_PredictTarget != EX_Target)));
  assign RedirectPC    = EX_Taken ? EX_Target : EX_PC + PcBits'(PC_INC);
  // Table storage: async clear, bulk invalidate, else single-entry write.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < Entries; i++) mem[i] <= {1'b0, (EntryBits-3)'(0), 2'(InitCounter)};
    end else if (adv && Invalidate) begin
      for (int i = 0; i < Entries; i++) mem[i][EntryBits-1] <= 1'b0;
    end else if (wr) begin
      mem[ex_idx] <= new_ent;
    end
  end
endmodule
